// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared constants and types for the SDRAM request arbiter
// Purpose: requester indices, age counter width and arbiter state encoding.
// Ports: none (package).
package sdram_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int AGE_W   = 3;

  localparam logic [1:0] REQ_M68K = 2'd0;
  localparam logic [1:0] REQ_CROM = 2'd1;
  localparam logic [1:0] REQ_SROM = 2'd2;
  localparam logic [1:0] REQ_CDWR = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection for the SDRAM request arbiter
// Purpose: choose one pending requester; an index whose age has reached
//          AGE_LIMIT beats base priority, otherwise the lowest index wins.
// Ports:
//   pending_i    latched outstanding requests
//   age_i        packed age counters, index i at [i*AGE_W +: AGE_W]
//   pick_idx_o   winning index (meaningful only when pick_valid_o=1)
//   pick_valid_o at least one request is pending
module arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int AGE_LIMIT = 4
) (
  input  logic [NUM_REQ-1:0]       pending_i,
  input  logic [NUM_REQ*AGE_W-1:0] age_i,
  output logic [1:0]               pick_idx_o,
  output logic                     pick_valid_o
);

  // Both loops scan from the top index down so the last hit is the lowest
  // index; the aged pass runs second so it overrides base priority.
  always_comb begin
    pick_idx_o = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_i[i]) pick_idx_o = 2'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_i[i] && (age_i[i*AGE_W +: AGE_W] == AGE_W'(AGE_LIMIT))) begin
        pick_idx_o = 2'(i);
      end
    end
  end

  assign pick_valid_o = |pending_i;

endmodule

// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - four-way SDRAM port arbiter with aging override
// Purpose: latch request strobes, grant one requester at a time and run the
//          RD/WR handshake with the SDRAM controller, returning read data and
//          a one-cycle completion pulse per requester.
// Ports:
//   CLK, nRESET           clock, asynchronous active-low reset
//   REQ[3:0]              request strobes (0=68k, 1=CROM, 2=SROM, 3=CD write)
//   SDRAM_READY           controller idle; low while a command is in flight
//   SDRAM_DOUT[63:0]      controller read data
//   SDRAM_RD/WR/BURST     command outputs
//   GNT_VALID, GNT_ID     active grant and its index (drives external addr mux)
//   DONE[3:0]             one-hot completion pulse
//   RDATA[63:0]           read data captured at completion
//   PENDING[3:0]          latched outstanding requests
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                 AGE_LIMIT  = 4,
  parameter logic [NUM_REQ-1:0] WR_MASK    = 4'b1000,
  parameter logic [NUM_REQ-1:0] BURST_MASK = 4'b0010
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               SDRAM_READY,
  input  logic [63:0]        SDRAM_DOUT,
  output logic               SDRAM_RD,
  output logic               SDRAM_WR,
  output logic               SDRAM_BURST,
  output logic               GNT_VALID,
  output logic [1:0]         GNT_ID,
  output logic [NUM_REQ-1:0] DONE,
  output logic [63:0]        RDATA,
  output logic [NUM_REQ-1:0] PENDING
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [AGE_W-1:0]   age_q [NUM_REQ];
  logic [AGE_W-1:0]   age_d [NUM_REQ];
  logic               rd_q, rd_d, wr_q, wr_d, burst_q, burst_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [63:0]        rdata_q, rdata_d;

  logic [NUM_REQ*AGE_W-1:0] age_flat;
  logic [1:0]               pick_idx;
  logic                     pick_valid;
  logic                     issue;

  always_comb begin
    age_flat = '0;
    for (int i = 0; i < NUM_REQ; i++) age_flat[i*AGE_W +: AGE_W] = age_q[i];
  end

  arb_pick #(.AGE_LIMIT(AGE_LIMIT)) u_pick (
    .pending_i   (pending_q),
    .age_i       (age_flat),
    .pick_idx_o  (pick_idx),
    .pick_valid_o(pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    burst_d     = burst_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    rdata_d     = rdata_q;
    done_d      = '0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid && SDRAM_READY) begin
          issue       = 1'b1;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
          wr_d        = WR_MASK[pick_idx];
          rd_d        = ~WR_MASK[pick_idx];
          burst_d     = BURST_MASK[pick_idx] & ~WR_MASK[pick_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // READY falling is the controller's acceptance of the command.
        if (!SDRAM_READY) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (SDRAM_READY) begin
          done_d[gnt_id_q] = 1'b1;
          gnt_valid_d      = 1'b0;
          burst_d          = 1'b0;
          if (!WR_MASK[gnt_id_q]) rdata_d = SDRAM_DOUT;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The strobe is OR'd after the grant clear so a strobe landing on the
  // issue cycle re-arms the request instead of being lost.
  always_comb begin
    pending_d = (pending_q & ~(issue ? (NUM_REQ'(1) << pick_idx) : '0)) | REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      age_d[i] = age_q[i];
      if (issue) begin
        if (2'(i) == pick_idx) begin
          age_d[i] = '0;
        end else if (pending_q[i] && (age_q[i] != AGE_W'(AGE_LIMIT))) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      burst_q     <= 1'b0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      done_q      <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      burst_q     <= burst_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
    end
  end

  assign SDRAM_RD    = rd_q;
  assign SDRAM_WR    = wr_q;
  assign SDRAM_BURST = burst_q;
  assign GNT_VALID   = gnt_valid_q;
  assign GNT_ID      = gnt_id_q;
  assign DONE        = done_q;
  assign RDATA       = rdata_q;
  assign PENDING     = pending_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb/tb_sdram_req_arbiter.sv - self-checking bench for sdram_req_arbiter
module tb_sdram_req_arbiter;
  import sdram_arb_pkg::*;

  localparam int         AGE_LIMIT = 4;
  localparam logic [3:0] WR_M      = 4'b1000;
  localparam logic [3:0] BURST_M   = 4'b0010;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [3:0]  REQ;
  logic        SDRAM_READY;
  logic [63:0] SDRAM_DOUT;
  logic        SDRAM_RD, SDRAM_WR, SDRAM_BURST, GNT_VALID;
  logic [1:0]  GNT_ID;
  logic [3:0]  DONE, PENDING;
  logic [63:0] RDATA;

  sdram_req_arbiter #(.AGE_LIMIT(AGE_LIMIT), .WR_MASK(WR_M), .BURST_MASK(BURST_M)) dut (
    .CLK(CLK), .nRESET(nRESET), .REQ(REQ), .SDRAM_READY(SDRAM_READY),
    .SDRAM_DOUT(SDRAM_DOUT), .SDRAM_RD(SDRAM_RD), .SDRAM_WR(SDRAM_WR),
    .SDRAM_BURST(SDRAM_BURST), .GNT_VALID(GNT_VALID), .GNT_ID(GNT_ID),
    .DONE(DONE), .RDATA(RDATA), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  // Controller model: accepts a command acc_dly cycles after seeing it,
  // completes busy_dly cycles later presenting next_dout.
  int          cst = 0, cnt = 0, acc_dly = 1, busy_dly = 3;
  bit          ctl_rand = 1'b0, ctl_block = 1'b0;
  logic        ready_int = 1'b1;
  logic [63:0] dout_r = 64'd0, next_dout = 64'd0;

  assign SDRAM_READY = ready_int & ~ctl_block;
  assign SDRAM_DOUT  = dout_r;

  initial begin
    forever begin
      @(negedge CLK);
      case (cst)
        0: if (SDRAM_RD || SDRAM_WR) begin
          cnt = 0;
          cst = 1;
          if (ctl_rand) begin
            acc_dly   = $urandom_range(1, 3);
            busy_dly  = $urandom_range(1, 4);
            next_dout = {$urandom, $urandom};
          end
        end
        1: begin
          cnt++;
          if (cnt >= acc_dly) begin ready_int = 1'b0; cnt = 0; cst = 2; end
        end
        default: begin
          cnt++;
          if (cnt >= busy_dly) begin ready_int = 1'b1; dout_r = next_dout; cst = 0; end
        end
      endcase
    end
  end

  // Reference model state
  logic [3:0]  m_pend;
  int          m_age [4];
  int          m_cur;
  logic [63:0] m_rdata;
  logic        prev_gv;
  int          glog[$];
  logic [3:0]  dlog[$];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    for (int i = 0; i < 4; i++) if (m_pend[i] && m_age[i] == AGE_LIMIT) return i;
    for (int i = 0; i < 4; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 4'd0; m_cur = -1; m_rdata = 64'd0; prev_gv = 1'b0;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
  endtask

  // One clock: drive REQ, advance to the next falling edge, update model, check.
  task automatic step(input logic [3:0] req);
    int w;
    REQ = req;
    @(negedge CLK);
    if (GNT_VALID && !prev_gv) begin
      w = model_winner();
      chk("gnt_id", 64'(GNT_ID), 64'(w));
      if (w >= 0) begin
        chk("gnt_rd", 64'(SDRAM_RD), 64'(!WR_M[w]));
        chk("gnt_wr", 64'(SDRAM_WR), 64'(WR_M[w]));
        chk("gnt_burst", 64'(SDRAM_BURST), 64'(BURST_M[w] & !WR_M[w]));
        for (int i = 0; i < 4; i++) begin
          if (i == w) m_age[i] = 0;
          else if (m_pend[i] && m_age[i] < AGE_LIMIT) m_age[i]++;
        end
        m_pend[w] = 1'b0;
        m_cur = w;
        glog.push_back(w);
      end
    end
    m_pend |= req;
    chk("pending", 64'(PENDING), 64'(m_pend));
    chk("rd_wr_excl", 64'(SDRAM_RD & SDRAM_WR), 64'd0);
    if (DONE != 4'd0) begin
      chk("done_onehot", 64'(DONE), (m_cur >= 0) ? (64'd1 << m_cur) : 64'd0);
      if (m_cur >= 0 && !WR_M[m_cur]) m_rdata = dout_r;
      chk("rdata", RDATA, m_rdata);
      dlog.push_back(DONE);
    end
    prev_gv = GNT_VALID;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_pend != 4'd0 || GNT_VALID || DONE != 4'd0) && n < 300) begin
      step(4'd0);
      n++;
    end
    chk("drain_timeout", 64'(n < 300), 64'd1);
  endtask

  initial begin
    int rd_cyc, burst_rd, done_cnt, n;
    nRESET = 1'b1;
    REQ = 4'd0;
    model_reset();
    #1 nRESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_rd", 64'(SDRAM_RD), 64'd0);
    chk("rst_wr", 64'(SDRAM_WR), 64'd0);
    chk("rst_burst", 64'(SDRAM_BURST), 64'd0);
    chk("rst_gv", 64'(GNT_VALID), 64'd0);
    chk("rst_gid", 64'(GNT_ID), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_rdata", RDATA, 64'd0);
    chk("rst_pend", 64'(PENDING), 64'd0);
    nRESET = 1'b1;

    // Single read
    acc_dly = 1; busy_dly = 5; next_dout = 64'h1234;
    glog.delete(); dlog.delete();
    rd_cyc = 0; burst_rd = 0;
    step(4'b1 << REQ_M68K);
    for (int i = 0; i < 20; i++) begin
      step(4'd0);
      if (SDRAM_RD) begin rd_cyc++; if (SDRAM_BURST) burst_rd++; end
    end
    chk("single_rd_cycles", 64'(rd_cyc), 64'd2);
    chk("single_burst", 64'(burst_rd), 64'd0);
    chk("single_done_cnt", 64'(dlog.size()), 64'd1);
    chk("single_done_val", (dlog.size() > 0) ? 64'(dlog[0]) : 64'hx, 64'b0001);
    chk("single_rdata", RDATA, 64'h1234);

    // Contention: CROM then SROM
    acc_dly = 1; busy_dly = 3;
    glog.delete(); dlog.delete();
    step(4'b0110);
    drain();
    chk("cont_n", 64'(glog.size()), 64'd2);
    chk("cont_first", (glog.size() > 0) ? 64'(glog[0]) : 64'hx, 64'(REQ_CROM));
    chk("cont_second", (glog.size() > 1) ? 64'(glog[1]) : 64'hx, 64'(REQ_SROM));
    chk("cont_done0", (dlog.size() > 0) ? 64'(dlog[0]) : 64'hx, 64'b0010);
    chk("cont_done1", (dlog.size() > 1) ? 64'(dlog[1]) : 64'hx, 64'b0100);

    // Starvation: 68k hammered, one CD write
    glog.delete();
    step(4'b1001);
    n = 0;
    while (glog.size() < 5 && n < 300) begin step(4'b0001); n++; end
    chk("starve_timeout", 64'(n < 300), 64'd1);
    drain();
    for (int i = 0; i < 4; i++)
      chk("starve_68k", (glog.size() > i) ? 64'(glog[i]) : 64'hx, 64'(REQ_M68K));
    chk("starve_cd", (glog.size() > 4) ? 64'(glog[4]) : 64'hx, 64'(REQ_CDWR));

    // Merge: three strobes while blocked give one grant
    glog.delete();
    ctl_block = 1'b1;
    step(4'b0100); step(4'd0); step(4'b0100); step(4'b0100);
    ctl_block = 1'b0;
    drain();
    chk("merge_n", 64'(glog.size()), 64'd1);

    // Re-arm: strobe on the issue cycle gives a second grant
    glog.delete();
    step(4'b0100);
    step(4'b0100);
    drain();
    chk("rearm_n", 64'(glog.size()), 64'd2);
    chk("rearm_id", (glog.size() > 1) ? 64'(glog[1]) : 64'hx, 64'(REQ_SROM));

    // Blocked controller
    glog.delete();
    ctl_block = 1'b1;
    step(4'b1111);
    for (int i = 0; i < 3; i++) begin
      step(4'd0);
      chk("blk_no_cmd", 64'(SDRAM_RD | SDRAM_WR | GNT_VALID), 64'd0);
    end
    chk("blk_pend", 64'(PENDING), 64'b1111);
    ctl_block = 1'b0;
    step(4'd0);
    chk("blk_gv", 64'(GNT_VALID), 64'd1);
    chk("blk_gid", 64'(GNT_ID), 64'(REQ_M68K));
    drain();
    chk("blk_n", 64'(glog.size()), 64'd4);

    // Randomized traffic against the model
    ctl_rand = 1'b1;
    for (int i = 0; i < 400; i++) step(4'($urandom) & 4'($urandom));
    ctl_rand = 1'b0;
    drain();

    // Asynchronous reset during WAIT_DONE
    acc_dly = 1; busy_dly = 8;
    step(4'b0001);
    n = 0;
    while (cst != 2 && n < 30) begin step(4'd0); n++; end
    chk("arst_wait", 64'(n < 30), 64'd1);
    step(4'b0100);
    #2 nRESET = 1'b0;
    REQ = 4'd0;
    #1;
    chk("arst_rd", 64'(SDRAM_RD), 64'd0);
    chk("arst_wr", 64'(SDRAM_WR), 64'd0);
    chk("arst_gv", 64'(GNT_VALID), 64'd0);
    chk("arst_pend", 64'(PENDING), 64'd0);
    chk("arst_done", 64'(DONE), 64'd0);
    cst = 0; cnt = 0; ready_int = 1'b1;
    model_reset();
    @(negedge CLK);
    nRESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(4'd0);
      chk("post_rst_idle", 64'(GNT_VALID | SDRAM_RD | SDRAM_WR), 64'd0);
      chk("post_rst_done", 64'(DONE), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
